// File: rtl/cofi_ctrl_if.sv
// Config request channel for the composite-blend sequencer.
// The requester (software/OSD side) drives the master modport; the
// sequencer consumes it through the slave modport.
interface cofi_ctrl_if #(
  parameter int DIV_W = 4
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_enable;
  logic [DIV_W-1:0] cfg_div;

  modport master (
    output cfg_valid,
    output cfg_enable,
    output cfg_div,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_enable,
    input  cfg_div,
    output cfg_ready
  );

endinterface

// File: rtl/cofi_ctrl.sv
// Composite-blend filter sequencer.
// Produces the blend stage's pixel clock-enable from a programmable divider
// and owns its enable. A new config is captured through the valid/ready
// channel, parked in pending registers, and only made active in the clock
// after the next vblank rising edge, so no frame ever sees mixed settings.
// If video timing is missing, a timer forces the apply and flags it.
module cofi_ctrl #(
  parameter int DIV_W     = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  cofi_ctrl_if.slave cfg,
  input  logic       vblank,
  output logic       pix_ce,
  output logic       blend_enable,
  output logic       busy,
  output logic       timeout,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TIMER_MAX = '1;

  state_t               state;
  state_t               state_nxt;
  logic                 rst_done;
  logic                 vblank_q;
  logic                 vb_rise;
  logic [TIMEOUT_W-1:0] timer;
  logic                 timer_done;
  logic                 pending_en;
  logic [DIV_W-1:0]     pending_div;
  logic [DIV_W-1:0]     div_act;
  logic [DIV_W-1:0]     div_cnt;
  logic                 capture;
  logic                 do_apply;
  logic                 force_apply;

  // A rising edge only counts when vblank is high now and was low last clock.
  assign vb_rise    = vblank & ~vblank_q;
  assign timer_done = (timer == TIMER_MAX);

  // Ready is held low for the first clock after reset release so the
  // release itself is synchronised before any request can be taken.
  assign cfg.cfg_ready = rst_done & (state == IDLE);
  assign busy          = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus the one-clock strobes that steer the datapath.
  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    do_apply    = 1'b0;
    force_apply = 1'b0;
    case (state)
      IDLE: begin
        if (cfg.cfg_valid && cfg.cfg_ready) begin
          capture   = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (vb_rise) begin
          state_nxt = APPLY;
        end else if (timer_done) begin
          force_apply = 1'b1;
          state_nxt   = APPLY;
        end
      end
      APPLY: begin
        do_apply  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Reset-release marker and vblank history for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      vblank_q <= vblank;
    end
  end

  // Frame counter advances on every vblank rising edge regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 8'd0;
    end else if (vb_rise) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Pending config is captured at the handshake and held until applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_en  <= 1'b0;
      pending_div <= '0;
    end else if (capture) begin
      pending_en  <= cfg.cfg_enable;
      pending_div <= cfg.cfg_div;
    end
  end

  // Timeout timer counts ARMED clocks and stops at its terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (capture) begin
      timer <= '0;
    end else if ((state == ARMED) && !vb_rise && !timer_done) begin
      timer <= timer + 1'b1;
    end
  end

  // Timeout flag is a single-clock pulse marking a forced apply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout <= 1'b0;
    end else begin
      timeout <= force_apply;
    end
  end

  // Active settings change only in APPLY; the divider phase is restarted
  // even when the new values equal the old ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blend_enable <= 1'b0;
      div_act      <= '0;
    end else if (do_apply) begin
      blend_enable <= pending_en;
      div_act      <= pending_div;
    end
  end

  // Pixel CE divider: fires when the down-counter is at zero, then reloads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      pix_ce  <= 1'b0;
    end else begin
      pix_ce <= (div_cnt == '0);
      if (do_apply) begin
        div_cnt <= '0;
      end else if (div_cnt == '0) begin
        div_cnt <= div_act;
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cofi_ctrl.sv
// Self-checking bench for cofi_ctrl.
// A behavioural model tracks what the outputs must be from the block's rules
// (pending request, ARMED age, clocks since the last CE phase restart) and is
// compared against the DUT on every falling edge. Directed sequences pin the
// model with hand-computed values, then a randomized phase exercises it.
`timescale 1ns/1ps
module tb_cofi_ctrl;

  localparam int DIV_W     = 4;
  localparam int TIMEOUT_W = 4;
  localparam int TMAX      = (1 << TIMEOUT_W) - 1;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       vblank = 1'b0;
  logic       pix_ce;
  logic       blend_enable;
  logic       busy;
  logic       timeout;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  cofi_ctrl_if #(.DIV_W(DIV_W)) cfg_bus ();

  cofi_ctrl #(
    .DIV_W    (DIV_W),
    .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg         (cfg_bus),
    .vblank      (vblank),
    .pix_ce      (pix_ce),
    .blend_enable(blend_enable),
    .busy        (busy),
    .timeout     (timeout),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_started;
  bit m_waiting;
  bit m_apply_next;
  int m_age;
  bit m_p_en;
  int m_p_div;
  int m_div;
  int m_since;
  bit m_vb_prev;
  bit exp_pix;
  bit exp_blend;
  bit exp_timeout;
  int exp_frame;

  task automatic modelReset();
    m_started    = 0;
    m_waiting    = 0;
    m_apply_next = 0;
    m_age        = 0;
    m_p_en       = 0;
    m_p_div      = 0;
    m_div        = 0;
    m_since      = 0;
    m_vb_prev    = 0;
    exp_pix      = 0;
    exp_blend    = 0;
    exp_timeout  = 0;
    exp_frame    = 0;
  endtask

  task automatic modelStep();
    bit rise;
    rise = vblank && !m_vb_prev;
    m_since++;
    exp_pix     = ((m_since - 1) % (m_div + 1)) == 0;
    exp_timeout = 0;
    if (rise) exp_frame = (exp_frame + 1) % 256;
    if (m_apply_next) begin
      exp_blend    = m_p_en;
      m_div        = m_p_div;
      m_since      = 0;
      m_apply_next = 0;
    end else if (m_waiting) begin
      if (rise) begin
        m_waiting    = 0;
        m_apply_next = 1;
      end else if (m_age == TMAX) begin
        m_waiting    = 0;
        m_apply_next = 1;
        exp_timeout  = 1;
      end else begin
        m_age++;
      end
    end else if (m_started && cfg_bus.cfg_valid) begin
      m_p_en    = cfg_bus.cfg_enable;
      m_p_div   = int'(cfg_bus.cfg_div);
      m_age     = 0;
      m_waiting = 1;
    end
    m_started = 1;
    m_vb_prev = vblank;
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput("cmp_pix_ce", pix_ce, exp_pix);
      checkOutput("cmp_blend_enable", blend_enable, exp_blend);
      checkOutput("cmp_timeout", timeout, exp_timeout);
      checkOutput("cmp_frame_cnt", frame_cnt, exp_frame);
      checkOutput("cmp_busy", busy, m_waiting || m_apply_next);
      checkOutput("cmp_cfg_ready", cfg_bus.cfg_ready, m_started && !m_waiting && !m_apply_next);
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input bit valid, input bit en, input int div, input bit vb);
    cfg_bus.cfg_valid  = valid;
    cfg_bus.cfg_enable = en;
    cfg_bus.cfg_div    = DIV_W'(div);
    vblank             = vb;
  endtask

  // Called just after a falling edge; reset edges sit clear of both clock edges.
  task automatic pulseReset(input int cycles);
    #2 rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic vblankPulse();
    vblank = 1'b1;
    @(negedge clk);
    vblank = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    applyStimulus(0, 0, 0, 0);
    rst_n = 1'b0;

    // Reset state and first clocks after release.
    repeat (3) @(negedge clk);
    checkOutput("rst_cfg_ready", cfg_bus.cfg_ready, 0);
    checkOutput("rst_pix_ce", pix_ce, 0);
    checkOutput("rst_frame_cnt", frame_cnt, 0);
    checkOutput("rst_busy", busy, 0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rel_cfg_ready", cfg_bus.cfg_ready, 1);
    checkOutput("rel_pix_ce", pix_ce, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("rel_pix_every_clk", pix_ce, 1);
      checkOutput("rel_blend_off", blend_enable, 0);
    end

    // Request enable=1, div=3; vblank first sampled high at t+11.
    applyStimulus(1, 1, 3, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    checkOutput("t2_busy", busy, 1);
    repeat (10) @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    checkOutput("t2_blend_not_yet", blend_enable, 0);
    @(negedge clk);
    checkOutput("t2_blend_applied", blend_enable, 1);
    checkOutput("t2_idle_again", busy, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("t2_ce_phase", pix_ce, (i % 4) == 0);
    end
    checkOutput("t2_frame_cnt", frame_cnt, 1);

    // Request captured in the same clock as a vblank rise: that rise is not used.
    vblank = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(1, 0, 1, 1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 1);
    checkOutput("t3_frame_cnt", frame_cnt, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t3_still_armed", busy, 1);
      checkOutput("t3_blend_held", blend_enable, 1);
    end
    vblank = 1'b0;
    @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t3_blend_applied", blend_enable, 0);
    checkOutput("t3_frame_cnt2", frame_cnt, 3);

    // No video timing: forced apply after the timer runs out.
    vblank = 1'b0;
    @(negedge clk);
    applyStimulus(1, 1, 2, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    n = 0;
    while (timeout !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_timeout_latency", n, 16);
    @(negedge clk);
    checkOutput("t4_timeout_pulse", timeout, 0);
    checkOutput("t4_blend_forced", blend_enable, 1);

    // Valid held through ARMED/APPLY: re-accepted only once IDLE returns.
    applyStimulus(1, 0, 5, 0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    vblank = 1'b1;
    @(negedge clk);
    checkOutput("t5_busy_apply", busy, 1);
    @(negedge clk);
    checkOutput("t5_idle_gap", busy, 0);
    checkOutput("t5_ready_gap", cfg_bus.cfg_ready, 1);
    checkOutput("t5_blend_off", blend_enable, 0);
    @(negedge clk);
    checkOutput("t5_reaccept", busy, 1);
    applyStimulus(0, 0, 0, 0);
    repeat (20) @(negedge clk);

    // Reset while ARMED drops the pending request.
    applyStimulus(1, 1, 7, 0);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_async_busy", busy, 0);
    checkOutput("t6_async_frame", frame_cnt, 0);
    checkOutput("t6_async_pix", pix_ce, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vblankPulse();
    repeat (3) @(negedge clk);
    checkOutput("t6_blend_dropped", blend_enable, 0);
    checkOutput("t6_busy_dropped", busy, 0);

    // Frame counter wrap: currently 1, 254 rises reach 255, then wrap.
    for (int i = 0; i < 254; i++) vblankPulse();
    checkOutput("t5_frame_255", frame_cnt, 255);
    vblankPulse();
    checkOutput("t5_frame_wrap", frame_cnt, 0);
    vblankPulse();
    checkOutput("t5_frame_after_wrap", frame_cnt, 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 499) == 0) begin
        pulseReset(2);
      end else begin
        cfg_bus.cfg_valid  = ($urandom_range(0, 3) == 0);
        cfg_bus.cfg_enable = $urandom_range(0, 1) != 0;
        cfg_bus.cfg_div    = DIV_W'($urandom_range(0, (1 << DIV_W) - 1));
        if ($urandom_range(0, 5) == 0) vblank = ~vblank;
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
